// File: rtl/ppi_mul_add_if.sv
`default_nettype none
// ============================================================================
// Module : ppi_mul_add_if
// Brief  : Sample/enable/result bundle between filt_ppi control and the MAC core
// Rev    : 1.0  initial release
// ============================================================================
interface ppi_mul_add_if #(
  parameter int gp_interpolation_factor = 4,
  parameter int gp_idata_width          = 8,
  parameter int c_sum_out_width         = 18
);
  logic                                                i_ena;
  logic [gp_interpolation_factor*gp_idata_width-1:0]  i_data;
  logic [gp_interpolation_factor*c_sum_out_width-1:0] o_data;

  modport master (output i_ena, output i_data, input  o_data);
  modport slave  (input  i_ena, input  i_data, output o_data);
endinterface
`default_nettype wire

// File: rtl/ppi_mul_add.sv
`default_nettype none
// ============================================================================
// Module : ppi_mul_add
// Brief  : Polyphase interpolator MAC array, one transposed-form FIR per phase
// Rev    : 1.0  initial release
// ============================================================================
module ppi_mul_add #(
  parameter int gp_interpolation_factor = 4,
  parameter int gp_coeff_length         = 16,
  parameter int gp_idata_width          = 8,
  parameter int gp_coeff_width          = 8,
  parameter logic [gp_coeff_length*gp_coeff_width-1:0] gp_coeffs = {
    8'sd16, 8'sd15, 8'sd14, 8'sd13, 8'sd12, 8'sd11, 8'sd10, 8'sd9,
    8'sd8,  8'sd7,  8'sd6,  8'sd5,  8'sd4,  8'sd3,  8'sd2,  8'sd1}
) (
  input  logic          i_clk,
  input  logic          i_rst_an,
  ppi_mul_add_if.slave  bus
);

  localparam int c_l             = gp_interpolation_factor;
  localparam int c_col           = gp_coeff_length / gp_interpolation_factor;
  localparam int c_mul_out_width = gp_idata_width + gp_coeff_width;
  localparam int c_sum_out_width = c_mul_out_width + $clog2(c_col);
  localparam int c_reg_out_width = c_sum_out_width;
  localparam int c_reg_cols      = (c_col > 1) ? c_col - 1 : 1;

  // Flattened buses, element index z = c*L + r
  logic [c_l*c_col*c_mul_out_width-1:0]      w_mul;
  logic [c_l*c_col*c_sum_out_width-1:0]      w_sum;
  logic [c_l*c_reg_cols*c_reg_out_width-1:0] w_reg;

  for (genvar r = 0; r < c_l; r++) begin : g_row
    logic signed [gp_idata_width-1:0]  lane;
    logic signed [c_sum_out_width-1:0] out_q;

    assign lane = bus.i_data[r*gp_idata_width +: gp_idata_width];

    for (genvar c = 0; c < c_col; c++) begin : g_col
      localparam int z = c*c_l + r;
      logic signed [gp_coeff_width-1:0]  coef;
      logic signed [c_mul_out_width-1:0] prod;
      logic signed [c_sum_out_width-1:0] prod_ext;

      assign coef     = gp_coeffs[z*gp_coeff_width +: gp_coeff_width];
      assign w_mul[z*c_mul_out_width +: c_mul_out_width] = lane * coef;
      assign prod     = w_mul[z*c_mul_out_width +: c_mul_out_width];
      assign prod_ext = prod;

      if (c < c_col - 1) begin : g_acc
        logic signed [c_reg_out_width-1:0] acc_q;
        logic signed [c_reg_out_width-1:0] acc;

        assign acc = w_reg[z*c_reg_out_width +: c_reg_out_width];
        assign w_sum[z*c_sum_out_width +: c_sum_out_width] = prod_ext + acc;

        // Each tap register takes the partial sum of the column to its right
        always_ff @(posedge i_clk or negedge i_rst_an) begin
          if (!i_rst_an) begin
            acc_q <= '0;
          end else if (bus.i_ena) begin
            acc_q <= w_sum[(z+c_l)*c_sum_out_width +: c_sum_out_width];
          end
        end
        assign w_reg[z*c_reg_out_width +: c_reg_out_width] = acc_q;
      end else begin : g_last
        assign w_sum[z*c_sum_out_width +: c_sum_out_width] = prod_ext;
      end
    end

    always_ff @(posedge i_clk or negedge i_rst_an) begin
      if (!i_rst_an) begin
        out_q <= '0;
      end else if (bus.i_ena) begin
        out_q <= w_sum[r*c_sum_out_width +: c_sum_out_width];
      end
    end
    assign bus.o_data[r*c_sum_out_width +: c_sum_out_width] = out_q;
  end

  if (c_col == 1) begin : g_no_reg
    assign w_reg = '0;
  end

endmodule
`default_nettype wire

// File: tb/tb_ppi_mul_add.sv
`default_nettype none
// ============================================================================
// Module : tb_ppi_mul_add
// Brief  : Self-checking bench, two instances (default and all -128 coefficients)
// Rev    : 1.0  initial release
// ============================================================================
module tb_ppi_mul_add;
  localparam int L   = 4;
  localparam int N   = 16;
  localparam int DW  = 8;
  localparam int CW  = 8;
  localparam int COL = N / L;
  localparam int SW  = 18;

  logic clk = 1'b0;
  logic rst_an = 1'b0;
  always #5 clk = ~clk;

  ppi_mul_add_if #(.gp_interpolation_factor(L), .gp_idata_width(DW), .c_sum_out_width(SW)) bus_a ();
  ppi_mul_add_if #(.gp_interpolation_factor(L), .gp_idata_width(DW), .c_sum_out_width(SW)) bus_b ();
  assign bus_b.i_ena  = bus_a.i_ena;
  assign bus_b.i_data = bus_a.i_data;

  ppi_mul_add #(.gp_interpolation_factor(L), .gp_coeff_length(N),
                .gp_idata_width(DW), .gp_coeff_width(CW)) dut_a (
    .i_clk(clk), .i_rst_an(rst_an), .bus(bus_a.slave));

  ppi_mul_add #(.gp_interpolation_factor(L), .gp_coeff_length(N),
                .gp_idata_width(DW), .gp_coeff_width(CW),
                .gp_coeffs({16{8'h80}})) dut_b (
    .i_clk(clk), .i_rst_an(rst_an), .bus(bus_b.slave));

  int checks = 0;
  int errors = 0;
  int ha[N];
  int hb[N];
  int hist[L][COL];   // hist[r][k] = lane r sample from k enabled edges ago

  typedef struct {
    logic        ena;
    logic [31:0] data;
    int          e0, e1, e2, e3;
  } vec_t;
  vec_t tbl[8];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  function automatic int row_a(input int r);
    logic signed [SW-1:0] v;
    v = bus_a.o_data[r*SW +: SW];
    return int'(v);
  endfunction

  function automatic int row_b(input int r);
    logic signed [SW-1:0] v;
    v = bus_b.o_data[r*SW +: SW];
    return int'(v);
  endfunction

  task automatic model_clear();
    for (int r = 0; r < L; r++)
      for (int k = 0; k < COL; k++) hist[r][k] = 0;
  endtask

  task automatic model_push(input logic [31:0] d);
    logic signed [DW-1:0] s;
    for (int r = 0; r < L; r++) begin
      for (int k = COL-1; k > 0; k--) hist[r][k] = hist[r][k-1];
      s = d[r*DW +: DW];
      hist[r][0] = int'(s);
    end
  endtask

  // y_r[n] = sum_k x_r[n-k] * h[k*L + r]
  function automatic int model_out(input int r, input bit use_b);
    int acc = 0;
    for (int k = 0; k < COL; k++)
      acc += hist[r][k] * (use_b ? hb[k*L + r] : ha[k*L + r]);
    return acc;
  endfunction

  task automatic check_model(input string tag);
    for (int r = 0; r < L; r++) begin
      chk($sformatf("%s_a_row%0d", tag, r), row_a(r), model_out(r, 1'b0));
      chk($sformatf("%s_b_row%0d", tag, r), row_b(r), model_out(r, 1'b1));
    end
  endtask

  task automatic check_zero(input string tag);
    for (int r = 0; r < L; r++) begin
      chk($sformatf("%s_a_row%0d", tag, r), row_a(r), 0);
      chk($sformatf("%s_b_row%0d", tag, r), row_b(r), 0);
    end
    chk({tag, "_a_wreg"}, int'(dut_a.w_reg == '0), 1);
    chk({tag, "_b_wreg"}, int'(dut_b.w_reg == '0), 1);
  endtask

  task automatic cyc(input logic ena, input logic [31:0] data, input string tag);
    bus_a.i_ena  = ena;
    bus_a.i_data = data;
    @(posedge clk);
    if (ena && rst_an) model_push(data);
    #1;
    check_model(tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_an = 1'b0;
    model_clear();
    #1;
    check_zero("rst");
    @(negedge clk);
    rst_an = 1'b1;
  endtask

  initial begin
    for (int k = 0; k < N; k++) begin
      ha[k] = k + 1;
      hb[k] = -128;
    end
    model_clear();

    // Reset held with live, non-zero, enabled input
    bus_a.i_ena  = 1'b1;
    bus_a.i_data = 32'h05050505;
    #1;
    check_zero("por");
    repeat (3) @(posedge clk);
    #1;
    check_zero("por_held");
    @(negedge clk);
    rst_an = 1'b1;

    // Impulse with an enable-off gap in the middle of the response
    tbl[0] = '{1'b1, 32'h01010101, 1,  2,  3,  4};
    tbl[1] = '{1'b1, 32'h00000000, 5,  6,  7,  8};
    tbl[2] = '{1'b0, 32'h7F7F7F7F, 5,  6,  7,  8};
    tbl[3] = '{1'b0, 32'h80808080, 5,  6,  7,  8};
    tbl[4] = '{1'b0, 32'h11223344, 5,  6,  7,  8};
    tbl[5] = '{1'b1, 32'h00000000, 9,  10, 11, 12};
    tbl[6] = '{1'b1, 32'h00000000, 13, 14, 15, 16};
    tbl[7] = '{1'b1, 32'h00000000, 0,  0,  0,  0};
    for (int i = 0; i < 8; i++) begin
      cyc(tbl[i].ena, tbl[i].data, $sformatf("imp%0d", i));
      chk($sformatf("tbl%0d_row0", i), row_a(0), tbl[i].e0);
      chk($sformatf("tbl%0d_row1", i), row_a(1), tbl[i].e1);
      chk($sformatf("tbl%0d_row2", i), row_a(2), tbl[i].e2);
      chk($sformatf("tbl%0d_row3", i), row_a(3), tbl[i].e3);
    end

    // Constant 5 on all lanes
    do_reset();
    for (int i = 0; i < 4; i++) cyc(1'b1, 32'h05050505, "const");
    for (int r = 0; r < L; r++) begin
      chk($sformatf("const_a_row%0d", r), row_a(r), 5 * (4*r + 28));
      chk($sformatf("const_b_row%0d", r), row_b(r), -2560);
    end

    // Most-negative lanes against most-negative coefficients
    do_reset();
    for (int i = 0; i < 4; i++) cyc(1'b1, 32'h80808080, "neg");
    for (int r = 0; r < L; r++) begin
      chk($sformatf("neg_b_row%0d", r), row_b(r), 65536);
      chk($sformatf("neg_a_row%0d", r), row_a(r), -128 * (4*r + 28));
    end
    // Lanes {-3,-127,-50,-120}
    for (int i = 0; i < 4; i++) cyc(1'b1, {8'h88, 8'hCE, 8'h81, 8'hFD}, "mix");
    chk("mix_b_row0", row_b(0), 1536);
    chk("mix_b_row1", row_b(1), 65024);
    chk("mix_b_row2", row_b(2), 25600);
    chk("mix_b_row3", row_b(3), 61440);

    // Lane-0 ramp after idle enabled cycles
    do_reset();
    for (int i = 0; i < 4; i++) cyc(1'b1, 32'h0, "idle");
    #4;
    begin
      int ramp_exp[6] = '{10, 61, 157, 302, 330, 358};
      for (int i = 0; i < 6; i++) begin
        cyc(1'b1, 32'(10 + i), $sformatf("ramp%0d", i));
        chk($sformatf("ramp%0d_row0", i), row_a(0), ramp_exp[i]);
        for (int r = 1; r < L; r++)
          chk($sformatf("ramp%0d_row%0d", i, r), row_a(r), 0);
      end
    end

    // Random stream with an asynchronous reset dropped mid-cycle
    do_reset();
    for (int i = 0; i < 300; i++) begin
      cyc(($urandom % 4) != 0, $urandom, "rnd");
      if (i == 150) begin
        #2;
        rst_an = 1'b0;
        model_clear();
        #1;
        check_zero("async");
        bus_a.i_ena  = 1'b1;
        bus_a.i_data = $urandom | 32'h01010101;
        @(posedge clk);
        #1;
        check_zero("async_held");
        @(negedge clk);
        rst_an = 1'b1;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
